// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_FLUSH   = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: load-use stalls, branch
// flushes and data-memory wait states, plus stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_keep,
  output logic             ifid_keep,
  output logic             ifid_nop,
  output logic             idex_keep,
  output logic             idex_nop,
  output logic             exmem_keep,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WT_W-1:0] WT_MAX = WT_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d, ret_q, ret_d, eff_state;
  logic [FC_W-1:0] flush_left_q, flush_left_d;
  logic [WT_W-1:0] wait_q, wait_d;
  logic            timeout_q, timeout_d;
  logic            mem_busy, load_use, flush_inc;

  assign mem_busy = dmem_req & ~dmem_ready;
  assign load_use = ex_memread & (ex_wreg != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_wreg)) |
                     (id_use_rs2 & (id_rs2 == ex_wreg)));

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    flush_left_d = flush_left_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    flush_inc    = 1'b0;
    pc_keep      = 1'b0;
    ifid_keep    = 1'b0;
    ifid_nop     = 1'b0;
    idex_keep    = 1'b0;
    idex_nop     = 1'b0;
    exmem_keep   = 1'b0;

    // Leaving MEM_WAIT applies the saved state's rules in the same cycle.
    eff_state = state_q;
    if ((state_q == HZ_MEMWAIT) && !mem_busy) begin
      eff_state = ret_q;
      state_d   = ret_q;
      wait_d    = '0;
    end

    case (eff_state)
      HZ_RUN: begin
        if (mem_busy) begin
          {pc_keep, ifid_keep, idex_keep, exmem_keep} = 4'b1111;
          ret_d   = HZ_RUN;
          state_d = HZ_MEMWAIT;
        end else if (ex_branch_taken) begin
          ifid_nop  = 1'b1;
          idex_nop  = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_left_d = FC_W'(FLUSH_CYCLES - 1);
            state_d      = HZ_FLUSH;
          end
        end else if (load_use) begin
          pc_keep   = 1'b1;
          ifid_keep = 1'b1;
          idex_nop  = 1'b1;
        end
      end
      HZ_FLUSH: begin
        if (mem_busy) begin
          {pc_keep, ifid_keep, idex_keep, exmem_keep} = 4'b1111;
          ret_d   = HZ_FLUSH;
          state_d = HZ_MEMWAIT;
        end else begin
          ifid_nop     = 1'b1;
          idex_nop     = 1'b1;
          flush_left_d = flush_left_q - FC_W'(1);
          if (flush_left_q == FC_W'(1)) begin
            state_d = HZ_RUN;
          end else begin
            state_d = HZ_FLUSH;
          end
        end
      end
      HZ_MEMWAIT: begin
        {pc_keep, ifid_keep, idex_keep, exmem_keep} = 4'b1111;
        wait_d    = (wait_q == WT_MAX) ? wait_q : wait_q + WT_W'(1);
        timeout_d = timeout_q | (wait_d == WT_MAX);
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    if (rst) begin
      pc_keep    = 1'b0;
      ifid_keep  = 1'b0;
      idex_keep  = 1'b0;
      exmem_keep = 1'b0;
      ifid_nop   = 1'b1;
      idex_nop   = 1'b1;
      flush_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HZ_RUN;
      ret_q        <= HZ_RUN;
      flush_left_q <= '0;
      wait_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      flush_left_q <= flush_left_d;
      wait_q       <= wait_d;
      timeout_q    <= timeout_d;
    end
  end

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_keep),
    .count (stall_cnt)
  );

  hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut_a (FLUSH_CYCLES=2, MEM_TIMEOUT=4) and
// dut_b (FLUSH_CYCLES=3, MEM_TIMEOUT=255) share the same stimulus.
module tb_hazard_ctrl;

  // Control vector order: {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep}
  localparam logic [5:0] CTL_IDLE = 6'b000000;
  localparam logic [5:0] CTL_LU   = 6'b110010;
  localparam logic [5:0] CTL_FL   = 6'b001010;
  localparam logic [5:0] CTL_MW   = 6'b110101;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_wreg;
  logic        id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
  logic        dmem_req, dmem_ready;

  logic        pc_keep_a, ifid_keep_a, ifid_nop_a, idex_keep_a, idex_nop_a, exmem_keep_a, mem_timeout_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  state_a;
  logic        pc_keep_b, ifid_keep_b, ifid_nop_b, idex_keep_b, idex_nop_b, exmem_keep_b, mem_timeout_b;
  logic [15:0] stall_cnt_b, flush_cnt_b;
  logic [1:0]  state_b;
  logic [5:0]  ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

  assign ctl_a = {pc_keep_a, ifid_keep_a, ifid_nop_a, idex_keep_a, idex_nop_a, exmem_keep_a};
  assign ctl_b = {pc_keep_b, ifid_keep_b, ifid_nop_b, idex_keep_b, idex_nop_b, exmem_keep_b};

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_wreg(ex_wreg), .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_keep(pc_keep_a), .ifid_keep(ifid_keep_a),
    .ifid_nop(ifid_nop_a), .idex_keep(idex_keep_a), .idex_nop(idex_nop_a),
    .exmem_keep(exmem_keep_a), .mem_timeout(mem_timeout_a), .stall_cnt(stall_cnt_a),
    .flush_cnt(flush_cnt_a), .state_o(state_a)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_wreg(ex_wreg), .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_keep(pc_keep_b), .ifid_keep(ifid_keep_b),
    .ifid_nop(ifid_nop_b), .idex_keep(idex_keep_b), .idex_nop(idex_nop_b),
    .exmem_keep(exmem_keep_b), .mem_timeout(mem_timeout_b), .stall_cnt(stall_cnt_b),
    .flush_cnt(flush_cnt_b), .state_o(state_b)
  );

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_wreg = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (ctl_a !== CTL_FL) begin errors++; $display("[TB] FAIL reset_ctl got %b want %b", ctl_a, CTL_FL); end
    next_cycle();
    #1;
    checks++;
    if (state_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state_a); end
    checks++;
    if ({stall_cnt_a, flush_cnt_a} !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnts got %0d/%0d want 0/0", stall_cnt_a, flush_cnt_a); end
    checks++;
    if (mem_timeout_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", mem_timeout_a); end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_wreg = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_LU) begin errors++; $display("[TB] FAIL lu_rs1_ctl got %b want %b", ctl_a, CTL_LU); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL lu_release_ctl got %b want %b", ctl_a, CTL_IDLE); end
    checks++;
    if (stall_cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt got %0d want 1", stall_cnt_a); end
    ex_memread = 1'b1; ex_wreg = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL lu_x0_ctl got %b want %b", ctl_a, CTL_IDLE); end
    next_cycle();
    clear_inputs();
    ex_memread = 1'b1; ex_wreg = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd7;
    #1;
    checks++;
    if (ctl_a !== CTL_LU) begin errors++; $display("[TB] FAIL lu_rs2_ctl got %b want %b", ctl_a, CTL_LU); end
    id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL lu_unused_ctl got %b want %b", ctl_a, CTL_IDLE); end
    ex_memread = 1'b0; id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL lu_noload_ctl got %b want %b", ctl_a, CTL_IDLE); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL lu_x0_stall_cnt got %0d want 1", stall_cnt_a); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_FL) begin errors++; $display("[TB] FAIL br_c0_ctl got %b want %b", ctl_a, CTL_FL); end
    next_cycle();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (ctl_a !== CTL_FL) begin errors++; $display("[TB] FAIL br_c1_ctl got %b want %b", ctl_a, CTL_FL); end
    checks++;
    if (state_a !== 2'd1) begin errors++; $display("[TB] FAIL br_c1_state got %0d want 1", state_a); end
    checks++;
    if (flush_cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL br_flush_cnt got %0d want 1", flush_cnt_a); end
    next_cycle();
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL br_c2_ctl got %b want %b", ctl_a, CTL_IDLE); end
    checks++;
    if (state_a !== 2'd0) begin errors++; $display("[TB] FAIL br_c2_state got %0d want 0", state_a); end
  endtask

  task automatic test_branch_and_load_use();
    do_reset();
    ex_branch_taken = 1'b1;
    ex_memread = 1'b1; ex_wreg = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_FL) begin errors++; $display("[TB] FAIL brlu_ctl got %b want %b", ctl_a, CTL_FL); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt_a !== 16'd0) begin errors++; $display("[TB] FAIL brlu_stall_cnt got %0d want 0", stall_cnt_a); end
    checks++;
    if (flush_cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL brlu_flush_cnt got %0d want 1", flush_cnt_a); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl_a !== CTL_MW) begin errors++; $display("[TB] FAIL mw_c%0d_ctl got %b want %b", i, ctl_a, CTL_MW); end
      checks++;
      if (state_a !== ((i == 0) ? 2'd0 : 2'd2)) begin errors++; $display("[TB] FAIL mw_c%0d_state got %0d", i, state_a); end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL mw_ready_ctl got %b want %b", ctl_a, CTL_IDLE); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (state_a !== 2'd0) begin errors++; $display("[TB] FAIL mw_done_state got %0d want 0", state_a); end
    checks++;
    if (stall_cnt_a !== 16'd3) begin errors++; $display("[TB] FAIL mw_stall_cnt got %0d want 3", stall_cnt_a); end
  endtask

  task automatic test_mem_wait_in_flush();
    do_reset();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl_b !== CTL_FL) begin errors++; $display("[TB] FAIL mwf_branch_ctl got %b want %b", ctl_b, CTL_FL); end
    next_cycle();
    ex_branch_taken = 1'b0;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl_b !== CTL_MW) begin errors++; $display("[TB] FAIL mwf_wait%0d_ctl got %b want %b", i, ctl_b, CTL_MW); end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_b !== CTL_FL) begin errors++; $display("[TB] FAIL mwf_resume_ctl got %b want %b", ctl_b, CTL_FL); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (ctl_b !== CTL_FL) begin errors++; $display("[TB] FAIL mwf_last_ctl got %b want %b", ctl_b, CTL_FL); end
    checks++;
    if (state_b !== 2'd1) begin errors++; $display("[TB] FAIL mwf_last_state got %0d want 1", state_b); end
    next_cycle();
    #1;
    checks++;
    if (ctl_b !== CTL_IDLE) begin errors++; $display("[TB] FAIL mwf_end_ctl got %b want %b", ctl_b, CTL_IDLE); end
    checks++;
    if ({stall_cnt_b, flush_cnt_b} !== {16'd3, 16'd1}) begin errors++; $display("[TB] FAIL mwf_cnts got %0d/%0d want 3/1", stall_cnt_b, flush_cnt_b); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (mem_timeout_a !== (i >= 5)) begin errors++; $display("[TB] FAIL to_c%0d got %b want %b", i, mem_timeout_a, (i >= 5)); end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_a !== CTL_IDLE) begin errors++; $display("[TB] FAIL to_ready_ctl got %b want %b", ctl_a, CTL_IDLE); end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (mem_timeout_a !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky got %b want 1", mem_timeout_a); end
    checks++;
    if (stall_cnt_a !== 16'd10) begin errors++; $display("[TB] FAIL to_stall_cnt got %0d want 10", stall_cnt_a); end
    checks++;
    if (mem_timeout_b !== 1'b0) begin errors++; $display("[TB] FAIL to_long_limit got %b want 0", mem_timeout_b); end
    do_reset();
    #1;
    checks++;
    if (mem_timeout_a !== 1'b0) begin errors++; $display("[TB] FAIL to_cleared got %b want 0", mem_timeout_a); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    ex_branch_taken = 1'b1;
    next_cycle();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (state_b !== 2'd1) begin errors++; $display("[TB] FAIL rmf_pre_state got %0d want 1", state_b); end
    rst = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (state_b !== 2'd0) begin errors++; $display("[TB] FAIL rmf_state got %0d want 0", state_b); end
    checks++;
    if ({stall_cnt_b, flush_cnt_b} !== 32'd0) begin errors++; $display("[TB] FAIL rmf_cnts got %0d/%0d want 0/0", stall_cnt_b, flush_cnt_b); end
    checks++;
    if (ctl_b !== CTL_FL) begin errors++; $display("[TB] FAIL rmf_forced_ctl got %b want %b", ctl_b, CTL_FL); end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl_b !== CTL_IDLE) begin errors++; $display("[TB] FAIL rmf_after_ctl got %b want %b", ctl_b, CTL_IDLE); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    $display("[TB] starting hazard_ctrl bench");
    test_reset();
    test_load_use();
    test_branch();
    test_branch_and_load_use();
    test_mem_wait();
    test_mem_wait_in_flush();
    test_timeout();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates keep (freeze) and nop (bubble) controls for the PC, IF/ID, ID/EX (decode stage `keep`/`nop`) and EX/MEM registers.
- Handles three cases: load-use stalls, taken-branch/jump flushes, and data-memory wait states.
- Also maintains stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, consecutive cycles of IF/ID + ID/EX bubbles per taken branch (minimum 1).
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout is set.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_rs1  in  5  ID-stage read_reg1.
- id_rs2  in  5  ID-stage read_reg2.
- id_use_rs1  in  1  ID instruction actually reads rs1.
- id_use_rs2  in  1  ID instruction actually reads rs2.
- ex_memread  in  1  EX-stage MemRW == 2'b10 (load).
- ex_wreg  in  5  EX-stage WReg.
- ex_branch_taken  in  1  EX resolved a taken branch or jal/jalr (level, held while EX is frozen).
- dmem_req  in  1  MEM stage has an active data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_keep  out  1  hold PC.
- ifid_keep  out  1  hold IF/ID register.
- ifid_nop  out  1  bubble IF/ID.
- idex_keep  out  1  decode `keep`.
- idex_nop  out  1  decode `nop`.
- exmem_keep  out  1  hold EX/MEM register.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  cycles with pc_keep = 1, saturating.
- flush_cnt  out  CNT_W  taken-branch flush events, saturating.
- state_o  out  2  current FSM state.

Behaviour:
- Outputs are combinational (Mealy) from the registered state and the current inputs. State, counters and flags update on posedge clk.
- Reset (rst = 1 at posedge):
  - state = RUN, flush counter = 0, wait counter = 0, stall_cnt = 0, flush_cnt = 0, mem_timeout = 0.
  - While rst = 1, outputs are forced: ifid_nop = idex_nop = 1, all keeps = 0.
- Definitions:
  - mem_busy = dmem_req & ~dmem_ready.
  - load_use = ex_memread & (ex_wreg != 0) & ((id_use_rs1 & id_rs1 == ex_wreg) | (id_use_rs2 & id_rs2 == ex_wreg)).
- States: RUN = 0, FLUSH = 1, MEM_WAIT = 2. Value 3 is illegal and recovers to RUN next cycle.
- Priority in every state: mem_busy > flush > load_use.
- RUN:
  - mem_busy: pc_keep = ifid_keep = idex_keep = exmem_keep = 1. Save return state = RUN, go to MEM_WAIT.
  - Else ex_branch_taken: ifid_nop = idex_nop = 1, flush_cnt += 1. If FLUSH_CYCLES > 1, load the flush counter with FLUSH_CYCLES-1 and go to FLUSH.
  - Else load_use: pc_keep = ifid_keep = 1 and idex_nop = 1 for exactly one cycle; stay in RUN.
  - Else: all outputs 0.
- FLUSH:
  - ifid_nop = idex_nop = 1; decrement the counter; return to RUN when it reaches 0.
  - load_use is ignored, since the ID instruction is wrong-path.
  - mem_busy takes priority: all keeps asserted, nops deasserted, counter paused, save return state = FLUSH, go to MEM_WAIT.
- MEM_WAIT:
  - All four keeps = 1 and both nops = 0 while mem_busy. Increment the wait counter, saturating at MEM_TIMEOUT.
  - Set mem_timeout when the wait counter equals MEM_TIMEOUT; it stays set until rst.
  - When mem_busy = 0: drop the keeps that cycle, clear the wait counter, and re-enter the saved state.
  - On re-entry, branch/load-use conditions are evaluated in that same cycle using the state's normal rules.
- A keep and a nop for the same register are never asserted together.
- stall_cnt increments on every cycle with pc_keep = 1, including rst = 0 cycles only. It saturates at all-ones.
- Reset in mid-FLUSH or mid-MEM_WAIT discards all pending work.

Decomposition:
- Add to define.v:
  - state encodings HZ_RUN, HZ_FLUSH, HZ_MEMWAIT.
  - MEMRW_LOAD = 2'b10.
- No sub-module. Optional hz_sat_counter (saturating counter) is shared by stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_memread = 1, ex_wreg = 5, id_rs1 = 5, id_use_rs1 = 1 → single cycle of pc_keep = ifid_keep = idex_nop = 1, stall_cnt 0→1. Repeat with ex_wreg = 0 → no stall.
- Branch with FLUSH_CYCLES = 2: ex_branch_taken = 1 for one cycle → ifid_nop = idex_nop = 1 for exactly 2 cycles, flush_cnt = 1, state_o sequence RUN→FLUSH→RUN.
- Simultaneous ex_branch_taken and load_use → flush only, pc_keep = 0, stall_cnt unchanged.
- Memory wait: dmem_req = 1, dmem_ready = 0 for 3 cycles then 1 → all keeps = 1 for 3 cycles, stall_cnt = 3, keeps drop on the ready cycle. Same sequence during FLUSH (FLUSH_CYCLES = 3) → flush resumes with its remaining count.
- Timeout with MEM_TIMEOUT = 4: dmem_ready held 0 for 10 cycles → mem_timeout rises after 4 wait cycles and stays 1 after ready, until rst.
- Reset mid-FLUSH: rst = 1 → next cycle state_o = 0, counters 0, ifid_nop = idex_nop = 1 while rst is high.
